// File: rtl/pulse_handshake_tx_pkg.sv
// Shared types and helpers for the multi-channel four-phase pulse transfer block.
package pulse_hs_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      RELEASE = 2'd2
   } hs_state_e;

   // Largest value a pending counter of the given width can hold.
   function automatic int unsigned pend_max(input int unsigned cnt_w);
      return (32'd1 << cnt_w) - 32'd1;
   endfunction

endpackage

// File: rtl/pulse_handshake_tx_if.sv
// Event, handshake and status bundle between the fast-side transmitter and its users.
interface pulse_handshake_tx_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 3
);
   logic [NUM_CH-1:0]       pulse_in;
   logic [NUM_CH-1:0]       ack_in;
   logic [NUM_CH-1:0]       ovf_clr;
   logic [NUM_CH-1:0]       req_out;
   logic [NUM_CH-1:0]       done;
   logic [NUM_CH-1:0]       busy;
   logic [NUM_CH*CNT_W-1:0] pending;
   logic [NUM_CH-1:0]       ovf;

   modport master (
      input  pulse_in, ack_in, ovf_clr,
      output req_out, done, busy, pending, ovf
   );

   modport slave (
      output pulse_in, ack_in, ovf_clr,
      input  req_out, done, busy, pending, ovf
   );
endinterface

// File: rtl/pulse_handshake_tx_sync_ff.sv
// Single-bit multi-flop synchroniser for an asynchronous level, synchronous reset.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);
   (* async_reg = "true", cdc_sync = "true" *)
   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/pulse_handshake_tx.sv
// Fast-side four-phase req/ack pulse transmitter: per-channel FSM, pending queue
// and sticky loss flag; channels are fully independent.
module pulse_handshake_tx
   import pulse_hs_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 3,
   parameter bit          QUEUE_EN    = 1'b1
) (
   input logic               clk,
   input logic               rst,
   pulse_handshake_tx_if.master bus
);
   localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(pend_max(CNT_W));

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      hs_state_e        r_state;
      hs_state_e        w_state_nxt;
      logic             w_ack_s;
      logic             w_take_pulse;
      logic             w_take_pend;
      logic             w_done_nxt;
      logic             w_evt_busy;
      logic             w_inc;
      logic             w_ovf_set;
      logic [CNT_W-1:0] w_pend_nxt;
      logic             r_req;
      logic             r_done;
      logic             r_ovf;
      logic [CNT_W-1:0] r_pend;

      sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
         .clk (clk),
         .rst (rst),
         .i_d (bus.ack_in[c]),
         .o_q (w_ack_s)
      );

      always_ff @(posedge clk) begin
         if (rst) r_state <= IDLE;
         else     r_state <= w_state_nxt;
      end

      // A fresh pulse is preferred over the queue when starting a transfer.
      always_comb begin
         w_state_nxt  = r_state;
         w_take_pulse = 1'b0;
         w_take_pend  = 1'b0;
         unique case (r_state)
            IDLE: begin
               if (bus.pulse_in[c]) begin
                  w_state_nxt  = REQ;
                  w_take_pulse = 1'b1;
               end else if (r_pend != '0) begin
                  w_state_nxt = REQ;
                  w_take_pend = 1'b1;
               end
            end
            REQ: begin
               if (w_ack_s) w_state_nxt = RELEASE;
            end
            RELEASE: begin
               if (!w_ack_s) begin
                  if (bus.pulse_in[c]) begin
                     w_state_nxt  = REQ;
                     w_take_pulse = 1'b1;
                  end else if (r_pend != '0) begin
                     w_state_nxt = REQ;
                     w_take_pend = 1'b1;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end

      // Unconsumed events are queued or dropped; the counter saturates at PEND_MAX.
      always_comb begin
         w_done_nxt = (r_state == RELEASE) && !w_ack_s;
         w_evt_busy = bus.pulse_in[c] && !w_take_pulse;
         w_inc      = w_evt_busy && QUEUE_EN && (r_pend != PEND_MAX);
         w_ovf_set  = w_evt_busy && (!QUEUE_EN || (r_pend == PEND_MAX));
         w_pend_nxt = r_pend;
         if (w_inc && !w_take_pend)      w_pend_nxt = r_pend + CNT_W'(1);
         else if (!w_inc && w_take_pend) w_pend_nxt = r_pend - CNT_W'(1);
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_req  <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_pend <= '0;
         end else begin
            r_req  <= (w_state_nxt == REQ);
            r_done <= w_done_nxt;
            r_ovf  <= w_ovf_set || (r_ovf && !bus.ovf_clr[c]);
            r_pend <= w_pend_nxt;
         end
      end

      assign bus.req_out[c]                = r_req;
      assign bus.done[c]                   = r_done;
      assign bus.ovf[c]                    = r_ovf;
      assign bus.pending[c*CNT_W +: CNT_W] = r_pend;
      assign bus.busy[c]                   = (r_state != IDLE) || (r_pend != '0);
   end
endmodule

// File: doc/pulse_handshake_tx.md
# pulse_handshake_tx

Multi-channel, fast-side half of a four-phase req/ack pulse-transfer handshake. Each channel captures single-cycle event pulses in the local `clk` domain, holds a level `req_out` until the receiving (slower or unrelated) domain acknowledges, then waits for the acknowledge to drop. Events that arrive while a channel is busy are queued or dropped, depending on mode. It replaces ad-hoc pulse wideners with a bounded, parametrised transfer block whose loss behaviour is defined.

## Interface
- `NUM_CH`, default 4: number of independent channels.
- `SYNC_STAGES`, default 2: flops in each `ack_in` synchroniser; legal range 2..4.
- `CNT_W`, default 3: width of the per-channel pending-event counter.
- `QUEUE_EN`, default 1:
  - 1 = count events that arrive while busy.
  - 0 = drop them and flag an error.
- `clk`, input, 1: only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `pulse_in`, input, NUM_CH: event strobes; each high cycle is one event.
- `ack_in`, input, NUM_CH: acknowledge from the far domain, asynchronous to `clk`.
- `req_out`, output, NUM_CH: registered request level to the far domain.
- `done`, output, NUM_CH: one-cycle strobe when a handshake completes.
- `busy`, output, NUM_CH: channel is not IDLE, or has a pending count above 0.
- `pending`, output, NUM_CH*CNT_W: per-channel pending counts; channel c occupies bits [c*CNT_W +: CNT_W].
- `ovf`, output, NUM_CH: sticky flag set when an event is lost.
- `ovf_clr`, input, NUM_CH: clears the matching `ovf` bit.

## Operation
- Per-channel FSM with three states: IDLE, REQ, RELEASE.
- `ack_s[c]` is the last stage of the `ack_in[c]` synchroniser. It is the only form of the acknowledge that the FSM uses.
- IDLE:
  - `pulse_in` high moves the channel to REQ, and `req_out` goes high.
  - If `pulse_in` is low and `pending` > 0, the channel moves to REQ and `pending` decrements.
- REQ:
  - `req_out` stays high.
  - `ack_s` = 1 moves the channel to RELEASE, and `req_out` goes low.
- RELEASE:
  - `req_out` stays low.
  - `ack_s` = 0 pulses `done` for one cycle.
  - On that same cycle, if `pending` > 0 or `pulse_in` = 1, the channel goes straight to REQ (back-to-back transfer). Otherwise it goes to IDLE.
  - When the back-to-back transfer is taken from the pending count rather than from `pulse_in`, `pending` decrements.
- Event while busy (state REQ or RELEASE, and not being consumed this cycle):
  - QUEUE_EN = 1: `pending` increments. If `pending` is already 2^CNT_W−1, it saturates and `ovf` is set.
  - QUEUE_EN = 0: the event is dropped and `ovf` is set. `pending` stays at 0.
- Simultaneous increment and decrement in one cycle: `pending` is unchanged.
- `ovf_clr` and a new overflow in the same cycle: `ovf` stays at 1 (set wins).
- Channels are fully independent; there is no shared arbitration.

## Timing
- Reset values:
  - All FSMs in IDLE.
  - `req_out` = 0, `done` = 0, `busy` = 0, `pending` = 0, `ovf` = 0.
  - All synchroniser flops = 0.
- `rst` overrides everything, including a handshake in flight. After reset, `req_out` is 0 on the next edge.
- The far side must tolerate an abandoned request; this is documented to integrators.
- `req_out` rises 1 cycle after `pulse_in` is sampled in IDLE.
- `req_out` falls 1 cycle after `ack_s` rises. This is SYNC_STAGES+1 `clk` cycles after `ack_in` rises.
- `done` is asserted in the cycle after `ack_s` is sampled low.
- Minimum round trip with an ideal far side: 2*(SYNC_STAGES+1) cycles plus the far-side latency.
- Throughput is one transfer per handshake. Sustained `pulse_in` faster than the handshake will fill `pending`.
- `busy` is combinational from the state and `pending`. All other outputs are registered.

## Structure
- Shared package `pulse_hs_pkg`:
  - FSM state enum {IDLE, REQ, RELEASE}.
  - Localparam `PEND_MAX = 2**CNT_W - 1` helper.
- Sub-module `sync_ff` (parameter STAGES): one-bit synchroniser chain with synchronous reset.
  - Instantiated NUM_CH times.
  - Marked for the CDC tool.
- Top level: a generate loop over channels, each holding its FSM, pending counter and `ovf` flop.

## Test plan
- Single event: NUM_CH=4, SYNC_STAGES=2, far-side model echoes `req_out` to `ack_in` after 5 cycles.
  - Pulse ch0 at cycle 10.
  - Required: `req_out[0]` high at cycle 11, low at cycle 19; `done[0]` at cycle 27.
  - Other channels stay idle.
- Queueing: QUEUE_EN=1, CNT_W=3. Pulse ch1 on 4 consecutive cycles.
  - Required: `pending[1]` reaches 3.
  - Four `done[1]` strobes occur, with back-to-back REQ and no IDLE cycle between them.
  - `ovf[1]` = 0 throughout.
- Saturation: 9 pulses while ch2 is in REQ.
  - Required: `pending` holds at 7 and `ovf[2]` = 1.
  - `ovf_clr[2]` asserted in the same cycle as a further pulse leaves `ovf[2]` at 1.
  - A later `ovf_clr[2]` clears it.
- Drop mode: QUEUE_EN=0, 2 pulses on ch3 while busy.
  - Required: exactly one `done[3]`, `ovf[3]` = 1, `pending` = 0.
- Simultaneous events: `pulse_in` arrives in the `done` cycle while `pending` = 1.
  - Required: the channel re-enters REQ and `pending` remains 1.
- Reset mid-handshake: assert `rst` while ch0 is in RELEASE.
  - Required: all outputs are at reset values 1 cycle later.
  - A fresh pulse afterwards completes normally.
